// File: rtl/priority_encoder_8_to_3_if.sv
// Request-vector in / index-beat out handshake bundle for priority_encoder_8_to_3.
// The encoder is the slave; the producer of vectors and consumer of beats is the master.
interface priority_encoder_8_to_3_if #(
  parameter int OUT_BIT = 3,
  parameter int INP_BIT = 2 ** OUT_BIT
);
  logic [INP_BIT-1:0] inp;
  logic               in_valid;
  logic               in_ready;
  logic [OUT_BIT-1:0] out;
  logic               out_valid;
  logic               out_ready;
  logic               last;

  modport master (
    output inp,
    output in_valid,
    input  in_ready,
    input  out,
    input  out_valid,
    output out_ready,
    input  last
  );

  modport slave (
    input  inp,
    input  in_valid,
    output in_ready,
    output out,
    output out_valid,
    input  out_ready,
    output last
  );
endinterface

// File: rtl/priority_encoder_8_to_3.sv
// Captures a request vector and streams out the index of every set bit, lowest first,
// one beat per out handshake, flagging the final beat with last.
module priority_encoder_8_to_3 #(
  parameter int OUT_BIT = 3,
  parameter int INP_BIT = 2 ** OUT_BIT
) (
  input logic                     clk,
  input logic                     rst_n,
  priority_encoder_8_to_3_if.slave bus
);

  localparam logic IDLE = 1'b0;
  localparam logic EMIT = 1'b1;

  logic               state;
  logic [INP_BIT-1:0] pending;
  logic [INP_BIT-1:0] pending_cleared;
  logic [OUT_BIT-1:0] low_idx;
  logic               single_bit;
  logic               emitting;

  // Clearing the lowest set bit is exactly "drop the beat just presented".
  assign pending_cleared = pending & (pending - INP_BIT'(1));
  assign single_bit      = (pending != '0) && (pending_cleared == '0);
  assign emitting        = (state == EMIT);

  always_comb begin
    // NOTE: default first, so every path assigns low_idx and no latch is inferred.
    low_idx = '0;
    for (int i = INP_BIT - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = OUT_BIT'(i);
    end
  end

  assign bus.in_ready  = ~emitting;
  assign bus.out_valid = emitting;
  assign bus.out       = emitting ? low_idx : '0;
  assign bus.last      = emitting & single_bit;

  // NOTE: non-blocking assignments so state and pending both see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          // All-zero vectors are accepted and dropped: no beat to emit.
          if (bus.in_valid && (bus.inp != '0)) begin
            pending <= bus.inp;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            pending <= pending_cleared;
            if (single_bit) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_encoder_8_to_3.sv
// Bench for priority_encoder_8_to_3: directed vector table, hand-written corner
// sequences and random traffic, all scored against a queue-of-beats reference model.
module tb_priority_encoder_8_to_3;
  localparam int OUT_BIT = 3;
  localparam int INP_BIT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  priority_encoder_8_to_3_if #(.OUT_BIT(OUT_BIT), .INP_BIT(INP_BIT)) bus ();

  priority_encoder_8_to_3 #(.OUT_BIT(OUT_BIT), .INP_BIT(INP_BIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an accepted vector becomes the ordered list of its set-bit indices.
  int q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (bus.in_valid) begin
        for (int i = 0; i < INP_BIT; i++) if (bus.inp[i]) q.push_back(i);
      end
    end else if (bus.out_ready) begin
      void'(q.pop_front());
    end
  end

  // Scoreboard compares {in_ready, out_valid, out, last} every cycle, mid-cycle.
  always @(negedge clk) begin
    logic [5:0] exp_v;
    exp_v = {q.size() == 0, q.size() != 0,
             (q.size() != 0) ? 3'(q[0]) : 3'd0, q.size() == 1};
    check("scoreboard {in_ready,out_valid,out,last}",
          {26'd0, bus.in_ready, bus.out_valid, bus.out, bus.last}, {26'd0, exp_v});
  end

  typedef struct {
    logic [7:0]  vec;
    int          count;
    logic [31:0] beats;  // expected index of beat k in nibble k
  } vec_t;

  vec_t table_v[6];

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle timeout at %0t: in_ready=%0b, required 1", $time, bus.in_ready);
    end
  endtask

  task automatic check_beat(input string name, input logic [2:0] idx, input logic lst);
    check(name, {27'd0, bus.out_valid, bus.out, bus.last}, {27'd0, 1'b1, idx, lst});
  endtask

  task automatic check_idle(input string name);
    check(name, {28'd0, bus.in_ready, bus.out_valid, bus.out, bus.last}, 32'h20);
  endtask

  initial begin
    table_v[0] = '{vec: 8'h01, count: 1, beats: 32'h0000_0000};
    table_v[1] = '{vec: 8'hA5, count: 4, beats: 32'h0000_7520};
    table_v[2] = '{vec: 8'h80, count: 1, beats: 32'h0000_0007};
    table_v[3] = '{vec: 8'h00, count: 0, beats: 32'h0000_0000};
    table_v[4] = '{vec: 8'hFF, count: 8, beats: 32'h7654_3210};
    table_v[5] = '{vec: 8'h18, count: 2, beats: 32'h0000_0043};

    // Reset with a full request vector offered.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.inp       = 8'hFF;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_idle("reset outputs");
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("no beat after reset release");
    end

    // Directed table at full throughput.
    foreach (table_v[t]) begin
      wait_idle();
      bus.inp       = table_v[t].vec;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      if (table_v[t].count == 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_idle("zero vector dropped");
      end else begin
        for (int k = 0; k < table_v[t].count; k++) begin
          @(negedge clk);
          if (k == 0) bus.in_valid = 1'b0;
          check_beat($sformatf("table %0d beat %0d", t, k),
                     table_v[t].beats[4*k +: 3], k == table_v[t].count - 1);
        end
        @(negedge clk);
        check_idle($sformatf("table %0d bubble", t));
      end
    end

    // Backpressure: first beat held while out_ready is low.
    wait_idle();
    bus.inp       = 8'h82;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) bus.in_valid = 1'b0;
      check_beat($sformatf("backpressure hold %0d", k), 3'd1, 1'b0);
      if (k == 3) bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check_beat("backpressure final", 3'd7, 1'b1);
    @(negedge clk);
    check_idle("backpressure bubble");

    // Zero vector, then overlap: requests offered during EMIT are ignored.
    wait_idle();
    bus.inp      = 8'h00;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_idle("zero vector in_ready stays");
    bus.inp = 8'h18;
    @(negedge clk);
    check_beat("overlap beat 3", 3'd3, 1'b0);
    bus.inp = 8'hFF;
    @(negedge clk);
    check_beat("overlap beat 4", 3'd4, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_idle("overlap not captured 1");
    @(negedge clk);
    check_idle("overlap not captured 2");

    // Reset during EMIT aborts the vector.
    wait_idle();
    bus.inp      = 8'hF0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_beat("midreset beat 4", 3'd4, 1'b0);
    @(negedge clk);
    check_beat("midreset beat 5", 3'd5, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_idle("midreset async abort");
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("midreset no stale beat");
    end

    // First edge after release accepts a vector.
    #2 rst_n = 1'b0;
    @(negedge clk);
    bus.inp      = 8'h01;
    bus.in_valid = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_beat("handshake on first edge after reset", 3'd0, 1'b1);
    @(negedge clk);
    check_idle("post reset bubble");

    // Random traffic against the scoreboard.
    for (int n = 0; n < 1500; n++) begin
      int r;
      @(negedge clk);
      r            = $urandom_range(0, 3);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.inp      = (r == 0) ? 8'h00 :
                     (r == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/priority_encoder_8_to_3.md
PRIORITY_ENCODER_8_TO_3 -- requirements
Module: priority_encoder_8_to_3

Interface
REQ-001 SHALL have parameter OUT_BIT, default 3, encoded index width.
REQ-002 SHALL have parameter INP_BIT, default 2**OUT_BIT, request vector width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port inp  input  INP_BIT  request bit vector, any number of bits set.
REQ-006 SHALL have port in_valid  input  1  inp is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept a vector this cycle.
REQ-008 SHALL have port out  output  OUT_BIT  binary index of the currently presented set bit.
REQ-009 SHALL have port out_valid  output  1  out is valid this cycle.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out this cycle.
REQ-011 SHALL have port last  output  1  current index is the final set bit of the captured vector.

Function
REQ-012 SHALL implement two states, IDLE and EMIT, plus an INP_BIT-wide pending register.
REQ-013 SHALL drive in_ready=1 exactly when state is IDLE; in_ready=0 in EMIT.
REQ-014 SHALL accept a vector on a rising edge with in_valid=1 and in_ready=1 (input handshake).
REQ-015 On an accepted nonzero vector, SHALL load pending=inp and move to EMIT; out_valid SHALL be 1 on the following cycle (one-cycle latency).
REQ-016 On an accepted all-zero vector, SHALL discard it, stay in IDLE, and emit no beat.
REQ-017 In EMIT, SHALL drive out_valid=1 and out=index of the lowest-numbered set bit of pending (bit 0 highest priority).
REQ-018 In EMIT, SHALL drive last=1 exactly when pending has one bit set.
REQ-019 On a rising edge with out_valid=1 and out_ready=1, SHALL clear the presented bit in pending; if last=1, SHALL return to IDLE.
REQ-020 While out_valid=1 and out_ready=0, out, last and pending SHALL stay unchanged.
REQ-021 in_valid and inp SHALL be ignored while in EMIT; no vector is captured or queued.
REQ-022 When out_valid=0, out and last SHALL be 0.
REQ-023 A vector with k set bits SHALL produce exactly k beats, in ascending index order, with last on the k-th only.
REQ-024 After the last beat handshake, in_ready SHALL be 1 on the next cycle (one bubble cycle between vectors).
REQ-025 With out_ready held 1, beats SHALL issue on consecutive cycles with no gaps.

Reset
REQ-026 While rst_n=0, state SHALL be IDLE and pending SHALL be 0, asynchronously and independent of clk.
REQ-027 During and right after reset: out_valid=0, out=0, last=0, in_ready=1.
REQ-028 Reset during EMIT SHALL abort the vector immediately; no remaining beats SHALL appear after rst_n rises.
REQ-029 The first input handshake after reset SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-030 Reset: rst_n=0 with in_valid=1, inp=8'hFF -> out_valid=0, out=0, last=0, in_ready=1, no beats after release until a new handshake.
REQ-031 Single bit: inp=8'b0000_0001, out_ready=1 -> one beat out=0, last=1; in_ready=1 on the next cycle.
REQ-032 Multi-bit: inp=8'b1010_0101, out_ready=1 -> beats out=0,2,5,7 on four consecutive cycles, last=1 only with out=7.
REQ-033 Backpressure: inp=8'b1000_0010, out_ready=0 for 3 cycles, then 1 -> out=1 (last=0) held stable 3 cycles, then out=1, then out=7 with last=1.
REQ-034 Zero and overlap: inp=0 accepted -> no out_valid, in_ready stays 1; in_valid=1 with inp=8'hFF during EMIT of 8'b0001_1000 -> only beats 3,4 emitted.
REQ-035 Mid-op reset: inp=8'b1111_0000, rst_n=0 after the beat out=4 -> out_valid=0 at once, in_ready=1, no beats 5/6/7 after release.
